// File: rtl/yolo_axis_output_framer.sv
// Output framer for the TinyYOLO compute unit: regenerates tlast from a programmed beat count,
// registers the stream through a 2-entry skid buffer and flags upstream framing errors.
module yolo_axis_output_framer #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_COUNT_WIDTH      = 32
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          ap_start,
    input  logic [C_COUNT_WIDTH-1:0]      cfg_total_beats,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic                          ap_done,
    output logic [C_COUNT_WIDTH-1:0]      beat_count,
    output logic                          err_early_tlast,
    output logic                          err_missing_tlast,
    output logic                          err_overrun
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                        state;
    state_t                        state_next;
    logic                          ap_start_q;
    logic                          start_rise;
    logic                          arm;
    logic                          arm_zero;
    logic [C_COUNT_WIDTH-1:0]      total_beats;
    logic [C_COUNT_WIDTH-1:0]      in_count;
    logic [C_AXIS_TDATA_WIDTH-1:0] buf_data [2];
    logic [1:0]                    buf_last;
    logic                          rd_ptr;
    logic                          wr_ptr;
    logic [1:0]                    occupancy;
    logic                          in_hs;
    logic                          push;
    logic                          pop;
    logic                          tag_last;

    assign start_rise = ap_start & ~ap_start_q;
    assign tag_last   = (in_count == total_beats - 1'b1);

    // Ready depends only on registered state and occupancy, never on m_axis_tready.
    assign s_axis_tready = ((state == RUN) && (occupancy != 2'd2)) || (state == DONE);
    assign in_hs         = s_axis_tvalid & s_axis_tready;
    assign push          = in_hs && (state == RUN);

    assign m_axis_tvalid = (occupancy != 2'd0);
    assign m_axis_tdata  = buf_data[rd_ptr];
    assign m_axis_tlast  = buf_last[rd_ptr];
    assign pop           = m_axis_tvalid & m_axis_tready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        arm        = 1'b0;
        arm_zero   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_rise) begin
                    arm = 1'b1;
                    if (cfg_total_beats != '0) begin
                        state_next = RUN;
                    end else begin
                        arm_zero   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            RUN: begin
                if (push && tag_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_axis_tlast) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ap_start_q        <= 1'b0;
            ap_done           <= 1'b0;
            total_beats       <= '0;
            in_count          <= '0;
            beat_count        <= '0;
            err_early_tlast   <= 1'b0;
            err_missing_tlast <= 1'b0;
            err_overrun       <= 1'b0;
        end else begin
            ap_start_q <= ap_start;
            ap_done    <= arm_zero | (pop & m_axis_tlast);
            if (arm) begin
                total_beats       <= cfg_total_beats;
                in_count          <= '0;
                beat_count        <= '0;
                err_early_tlast   <= 1'b0;
                err_missing_tlast <= 1'b0;
                err_overrun       <= 1'b0;
            end else begin
                if (push) begin
                    in_count <= in_count + 1'b1;
                    if (s_axis_tlast && !tag_last) begin
                        err_early_tlast <= 1'b1;
                    end
                    if (!s_axis_tlast && tag_last) begin
                        err_missing_tlast <= 1'b1;
                    end
                end
                if (in_hs && (state == DONE)) begin
                    err_overrun <= 1'b1;
                end
                if (pop && (beat_count != '1)) begin
                    beat_count <= beat_count + 1'b1;
                end
            end
        end
    end

    // Two-slot ring; the head slot is untouched while stalled, which keeps tdata/tlast stable.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
            end
            buf_last  <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= s_axis_tdata;
                buf_last[wr_ptr] <= tag_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_yolo_axis_output_framer.sv
// Randomised scoreboard bench for yolo_axis_output_framer: the driver queues the beats a frame
// should emit, and an independent monitor checks every downstream cycle against that queue.
module tb_yolo_axis_output_framer;

    localparam int DW = 64;
    localparam int CW = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } beat_t;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          ap_start = 1'b0;
    logic [CW-1:0] cfg_total_beats = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tlast = 1'b0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          ap_done;
    logic [CW-1:0] beat_count;
    logic          err_early_tlast;
    logic          err_missing_tlast;
    logic          err_overrun;

    beat_t sb[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    done_count = 0;
    int    done_cyc = -1;
    int    exp_done = 0;
    bit    allow_done = 1'b0;
    bit    lat_check = 1'b0;
    bit    ready_rand = 1'b0;
    bit    ready_force = 1'b1;

    yolo_axis_output_framer #(
        .C_AXIS_TDATA_WIDTH(DW),
        .C_COUNT_WIDTH(CW)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .ap_start(ap_start),
        .cfg_total_beats(cfg_total_beats),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast),
        .ap_done(ap_done),
        .beat_count(beat_count),
        .err_early_tlast(err_early_tlast),
        .err_missing_tlast(err_missing_tlast),
        .err_overrun(err_overrun)
    );

    always #5 aclk = ~aclk;

    task automatic checkVal(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input int exp_beats, input bit e_early,
                               input bit e_missing, input bit e_overrun);
        checkVal({name, ".beat_count"}, 64'(beat_count), 64'(exp_beats));
        checkVal({name, ".err_early_tlast"}, 64'(err_early_tlast), 64'(e_early));
        checkVal({name, ".err_missing_tlast"}, 64'(err_missing_tlast), 64'(e_missing));
        checkVal({name, ".err_overrun"}, 64'(err_overrun), 64'(e_overrun));
    endtask

    task automatic checkIdle(input string name);
        checkVal({name, ".m_axis_tvalid"}, 64'(m_axis_tvalid), 64'(0));
        checkVal({name, ".m_axis_tdata"}, m_axis_tdata, 64'(0));
        checkVal({name, ".m_axis_tlast"}, 64'(m_axis_tlast), 64'(0));
        checkVal({name, ".s_axis_tready"}, 64'(s_axis_tready), 64'(0));
        checkVal({name, ".ap_done"}, 64'(ap_done), 64'(0));
    endtask

    task automatic arm(input int total);
        @(posedge aclk);
        #1;
        ap_start        = 1'b1;
        cfg_total_beats = CW'(total);
        @(posedge aclk);
        #1;
        ap_start = 1'b0;
    endtask

    // Offers n_offer beats; the first n_total handshakes are the frame, later ones are overrun.
    task automatic applyStimulus(input int n_total, input int n_offer, input int early_idx,
                                 input bit missing, input int valid_pct);
        int            idx = 0;
        int            budget = 0;
        bit            hs;
        logic [DW-1:0] cur;
        beat_t         ent;
        cur = {$urandom(), $urandom()};
        while (idx < n_offer && budget < 500) begin
            s_axis_tvalid = (int'($urandom_range(99)) < valid_pct);
            s_axis_tdata  = cur;
            s_axis_tlast  = ((idx == n_total - 1) && !missing) || (idx == early_idx);
            @(negedge aclk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge aclk);
            if (hs) begin
                if (idx < n_total) begin
                    ent.data = cur;
                    ent.last = (idx == n_total - 1);
                    ent.cyc  = cyc;
                    sb.push_back(ent);
                end
                idx++;
                cur = {$urandom(), $urandom()};
            end
            budget++;
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        checkVal("stim_handshakes", 64'(idx), 64'(n_offer));
    endtask

    task automatic waitDone(input int budget);
        exp_done++;
        for (int i = 0; i < budget; i++) begin
            @(posedge aclk);
            if (done_count >= exp_done) break;
        end
        #1;
        checkVal("frame_done_count", 64'(done_count), 64'(exp_done));
    endtask

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            m_axis_tready = ready_rand ? 1'($urandom_range(1)) : ready_force;
        end
    end

    // Monitor: the queue holds exactly the beats accepted but not yet delivered.
    initial begin
        beat_t head;
        forever begin
            @(negedge aclk);
            cyc++;
            if (areset) begin
                sb.delete();
                done_cyc = -1;
            end else begin
                checkVal("m_tvalid_vs_model", 64'(m_axis_tvalid), 64'(sb.size() != 0));
                checkVal("s_tready_when_full", 64'(s_axis_tready && (sb.size() >= 2)), 64'(0));
                if (m_axis_tvalid && sb.size() != 0) begin
                    head = sb[0];
                    checkVal("m_tdata", m_axis_tdata, head.data);
                    checkVal("m_tlast", 64'(m_axis_tlast), 64'(head.last));
                    if (m_axis_tready) begin
                        if (lat_check) checkVal("latency", 64'(cyc), 64'(head.cyc + 1));
                        void'(sb.pop_front());
                        if (head.last) done_cyc = cyc + 1;
                    end
                end
                if (cyc == done_cyc) begin
                    checkVal("ap_done_pulse", 64'(ap_done), 64'(1));
                    if (ap_done) done_count++;
                end else if (!allow_done) begin
                    checkVal("ap_done_quiet", 64'(ap_done), 64'(0));
                end
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        checkIdle("reset");
        checkOutput("reset", 0, 0, 0, 0);

        // Clean 4-beat frame with the sink always ready.
        lat_check = 1'b1;
        arm(4);
        applyStimulus(4, 4, -1, 1'b0, 100);
        waitDone(50);
        lat_check = 1'b0;
        @(negedge aclk);
        checkOutput("frame4", 4, 0, 0, 0);

        // Random valid and random sink back-pressure.
        ready_rand = 1'b1;
        arm(8);
        applyStimulus(8, 8, -1, 1'b0, 60);
        waitDone(200);
        ready_rand = 1'b0;
        @(negedge aclk);
        checkOutput("frame8", 8, 0, 0, 0);

        // Early tlast on beat 2 and no tlast on beat 3.
        arm(3);
        applyStimulus(3, 3, 1, 1'b1, 100);
        waitDone(50);
        @(negedge aclk);
        checkOutput("frame3_err", 3, 1, 1, 0);

        // Three extra beats after a 2-beat frame are swallowed as overrun.
        arm(2);
        applyStimulus(2, 5, -1, 1'b0, 100);
        waitDone(50);
        @(negedge aclk);
        checkOutput("frame2_overrun", 2, 0, 0, 1);

        // Zero-length arm.
        allow_done = 1'b1;
        arm(0);
        @(negedge aclk);
        checkVal("zero.ap_done", 64'(ap_done), 64'(1));
        checkVal("zero.s_tready", 64'(s_axis_tready), 64'(0));
        checkVal("zero.beat_count", 64'(beat_count), 64'(0));
        @(negedge aclk);
        checkVal("zero.ap_done_end", 64'(ap_done), 64'(0));
        allow_done = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            checkVal("zero.s_tready_idle", 64'(s_axis_tready), 64'(0));
        end

        // Reset in the middle of a 6-beat frame with one beat sitting in the buffer.
        #1;
        arm(6);
        ready_force = 1'b1;
        applyStimulus(6, 1, 0, 1'b0, 100);
        repeat (3) @(posedge aclk);
        #1;
        ready_force = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        applyStimulus(6, 1, -1, 1'b0, 100);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        checkIdle("mid_reset");
        checkOutput("mid_reset", 0, 0, 0, 0);
        repeat (4) @(posedge aclk);
        #1;
        ready_force = 1'b1;
        arm(6);
        applyStimulus(6, 6, -1, 1'b0, 80);
        waitDone(100);
        @(negedge aclk);
        checkOutput("frame6_after_reset", 6, 0, 0, 0);

        repeat (3) @(posedge aclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
